// File: rtl/uart_int_src_pkg.sv
// Shared types for the UART interrupt-source block: IIR codes, RX trigger
// selection, the sticky LSR error bundle and the default character timeout.
package uart_int_src_pkg;

  typedef enum logic [3:0] {
    INT_MODEM_STATUS   = 4'h0,
    INT_NONE           = 4'h1,
    INT_THR_EMPTY      = 4'h2,
    INT_RX_DATA_READY  = 4'h4,
    INT_RX_LINE_STATUS = 4'h6,
    INT_RX_TIMEOUT     = 4'hC
  } int_code_e;

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_4  = 2'd1,
    TRIG_8  = 2'd2,
    TRIG_14 = 2'd3
  } rx_trig_e;

  typedef struct packed {
    logic bi;
    logic fe;
    logic pe;
    logic oe;
  } lsr_err_s;

  localparam int UART_TO_CHARS = 4;

  // With the FIFO disabled the receiver behaves as a one-character holding register.
  function automatic int unsigned trig_chars(input logic fifo_en, input rx_trig_e trig);
    if (!fifo_en) return 1;
    case (trig)
      TRIG_1:  return 1;
      TRIG_4:  return 4;
      TRIG_8:  return 8;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/uart_int_src_if.sv
// Bundle of FIFO/baud/register-strobe inputs and interrupt-flag outputs
// exchanged between the UART datapath and the interrupt-source block.
interface uart_int_src_if #(parameter int FIFO_DEPTH = 16);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                          rx_push;
  logic [2:0]                    rx_err;
  logic                          rx_overrun;
  logic [LW-1:0]                 rx_level;
  logic                          tx_fifo_empty;
  logic                          char_tick;
  logic                          lsr_rd;
  logic                          rbr_rd;
  logic                          iir_rd;
  logic                          thr_wr;
  uart_int_src_pkg::int_code_e   iir_code;
  logic                          cfg_fifo_en;
  logic [1:0]                    cfg_rx_trig;
  logic                          cfg_thr_en;

  logic [3:0]                    lsr_err;
  logic                          int_rx_line_status;
  logic                          int_rx_data_ready;
  logic                          int_rx_timeout;
  logic                          int_tx_fifo_empty;

  modport master (
    output rx_push, rx_err, rx_overrun, rx_level, tx_fifo_empty, char_tick,
           lsr_rd, rbr_rd, iir_rd, thr_wr, iir_code,
           cfg_fifo_en, cfg_rx_trig, cfg_thr_en,
    input  lsr_err, int_rx_line_status, int_rx_data_ready, int_rx_timeout,
           int_tx_fifo_empty
  );

  modport slave (
    input  rx_push, rx_err, rx_overrun, rx_level, tx_fifo_empty, char_tick,
           lsr_rd, rbr_rd, iir_rd, thr_wr, iir_code,
           cfg_fifo_en, cfg_rx_trig, cfg_thr_en,
    output lsr_err, int_rx_line_status, int_rx_data_ready, int_rx_timeout,
           int_tx_fifo_empty
  );

endinterface

// File: rtl/uart_int_src_rx_timeout.sv
// RX character-timeout tracker: counts character times of receiver inactivity
// while data sits in the FIFO and raises a flag once the limit is reached.
module uart_rx_timeout #(
  parameter int TO_CHARS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic char_tick,
  output logic timeout
);

  localparam int            CW     = $clog2(TO_CHARS + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TO_CHARS);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturate at the limit so a long idle period keeps the flag asserted.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (char_tick && (count_q != TO_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      timeout <= 1'b0;
    end else begin
      count_q <= count_d;
      timeout <= (count_d == TO_MAX);
    end
  end

endmodule

// File: rtl/uart_int_src.sv
// Produces the four 16550-style interrupt source flags (line status, RX data
// ready, RX timeout, THR empty) for the UART interrupt controller.
module uart_int_src
  import uart_int_src_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TO_CHARS   = UART_TO_CHARS
) (
  input  logic          clk,
  input  logic          rst,
  uart_int_src_if.slave bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [LW-1:0] level;
  lsr_err_s      err_set;
  lsr_err_s      err_d;
  lsr_err_s      err_q;
  logic          line_status_q;
  logic          data_ready_d;
  logic          data_ready_q;
  logic          rx_idle_clear;
  logic          rx_timeout;
  logic          tx_empty_q;
  logic          thr_en_q;
  logic          thre_set;
  logic          thre_iir_clr;
  logic          thre_q;

  assign level = bus.rx_level;

  // A read of LSR clears the old errors but must not swallow one arriving in the same cycle.
  always_comb begin
    err_set.bi = bus.rx_push & bus.rx_err[2];
    err_set.fe = bus.rx_push & bus.rx_err[1];
    err_set.pe = bus.rx_push & bus.rx_err[0];
    err_set.oe = bus.rx_overrun;
    err_d      = bus.lsr_rd ? err_set : (err_q | err_set);
  end

  assign data_ready_d = 32'(level) >= trig_chars(bus.cfg_fifo_en, rx_trig_e'(bus.cfg_rx_trig));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q         <= '0;
      line_status_q <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      err_q         <= err_d;
      line_status_q <= |err_d;
      data_ready_q  <= data_ready_d;
    end
  end

  assign rx_idle_clear = (level == '0) | bus.rx_push | bus.rbr_rd | ~bus.cfg_fifo_en;

  uart_rx_timeout #(
    .TO_CHARS (TO_CHARS)
  ) u_rx_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (rx_idle_clear),
    .char_tick (bus.char_tick),
    .timeout   (rx_timeout)
  );

  // The empty history resets high so coming out of reset with an idle transmitter raises nothing.
  assign thre_set     = (bus.tx_fifo_empty & ~tx_empty_q) |
                        (bus.cfg_thr_en & ~thr_en_q & bus.tx_fifo_empty);
  assign thre_iir_clr = bus.iir_rd && (bus.iir_code == INT_THR_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_empty_q <= 1'b1;
      thr_en_q   <= 1'b0;
      thre_q     <= 1'b0;
    end else begin
      tx_empty_q <= bus.tx_fifo_empty;
      thr_en_q   <= bus.cfg_thr_en;
      if (bus.thr_wr) begin
        thre_q <= 1'b0;
      end else if (thre_set) begin
        thre_q <= 1'b1;
      end else if (thre_iir_clr) begin
        thre_q <= 1'b0;
      end
    end
  end

  assign bus.lsr_err            = err_q;
  assign bus.int_rx_line_status = line_status_q;
  assign bus.int_rx_data_ready  = data_ready_q;
  assign bus.int_rx_timeout     = rx_timeout;
  assign bus.int_tx_fifo_empty  = thre_q;

endmodule

// File: tb/tb_uart_int_src.sv
// Directed vector table plus randomized traffic against a rule-level model
// of the UART interrupt-source flags.
module tb_uart_int_src;
  import uart_int_src_pkg::*;

  localparam int FIFO_DEPTH = 16;
  localparam int TO_CHARS   = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  typedef struct {
    logic          rst;
    logic          rx_push;
    logic [2:0]    rx_err;
    logic          rx_overrun;
    logic [LW-1:0] rx_level;
    logic          tx_fifo_empty;
    logic          char_tick;
    logic          lsr_rd;
    logic          rbr_rd;
    logic          iir_rd;
    logic          thr_wr;
    int_code_e     iir_code;
    logic          cfg_fifo_en;
    logic [1:0]    cfg_rx_trig;
    logic          cfg_thr_en;
  } stim_t;

  // exp packs {lsr_err[3:0], line_status, data_ready, timeout, thre}
  typedef struct {
    stim_t      s;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  logic [3:0] m_err;
  int         m_idle_chars;
  logic       m_dr;
  logic       m_thre;
  logic       m_prev_tx;
  logic       m_prev_en;
  int         trig_table[4] = '{1, 4, 8, 14};

  uart_int_src_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_int_src #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TO_CHARS   (TO_CHARS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b0; s.rx_push = 1'b0; s.rx_err = 3'b000; s.rx_overrun = 1'b0;
    s.rx_level = '0; s.tx_fifo_empty = 1'b1; s.char_tick = 1'b0;
    s.lsr_rd = 1'b0; s.rbr_rd = 1'b0; s.iir_rd = 1'b0; s.thr_wr = 1'b0;
    s.iir_code = INT_NONE; s.cfg_fifo_en = 1'b1; s.cfg_rx_trig = 2'd0; s.cfg_thr_en = 1'b0;
    return s;
  endfunction

  function automatic stim_t strobes_off(input stim_t s);
    stim_t r = s;
    r.rst = 1'b0; r.rx_push = 1'b0; r.rx_err = 3'b000; r.rx_overrun = 1'b0;
    r.char_tick = 1'b0; r.lsr_rd = 1'b0; r.rbr_rd = 1'b0; r.iir_rd = 1'b0;
    r.thr_wr = 1'b0; r.iir_code = INT_NONE;
    return r;
  endfunction

  // Rule-level model: errors accumulate until read, data ready compares level to the
  // selected threshold, idle character times are counted, THRE tracks set/clear events.
  task automatic model_step(input stim_t s);
    logic [3:0] new_err;
    int         trig;
    logic       rise;
    if (s.rst) begin
      m_err = 4'b0; m_dr = 1'b0; m_idle_chars = 0; m_thre = 1'b0;
      m_prev_tx = 1'b1; m_prev_en = 1'b0;
      return;
    end
    new_err = {s.rx_push ? s.rx_err : 3'b000, s.rx_overrun};
    m_err   = s.lsr_rd ? new_err : (m_err | new_err);
    trig    = s.cfg_fifo_en ? trig_table[s.cfg_rx_trig] : 1;
    m_dr    = int'(s.rx_level) >= trig;
    if (s.rx_level == 0 || s.rx_push || s.rbr_rd || !s.cfg_fifo_en) m_idle_chars = 0;
    else if (s.char_tick && m_idle_chars < TO_CHARS) m_idle_chars++;
    rise = (s.tx_fifo_empty && !m_prev_tx) || (s.cfg_thr_en && !m_prev_en && s.tx_fifo_empty);
    if (s.thr_wr) m_thre = 1'b0;
    else if (rise) m_thre = 1'b1;
    else if (s.iir_rd && s.iir_code == INT_THR_EMPTY) m_thre = 1'b0;
    m_prev_tx = s.tx_fifo_empty;
    m_prev_en = s.cfg_thr_en;
  endtask

  function automatic logic [7:0] model_out();
    return {m_err, |m_err, m_dr, (m_idle_chars >= TO_CHARS), m_thre};
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst               = s.rst;
    bus.rx_push       = s.rx_push;
    bus.rx_err        = s.rx_err;
    bus.rx_overrun    = s.rx_overrun;
    bus.rx_level      = s.rx_level;
    bus.tx_fifo_empty = s.tx_fifo_empty;
    bus.char_tick     = s.char_tick;
    bus.lsr_rd        = s.lsr_rd;
    bus.rbr_rd        = s.rbr_rd;
    bus.iir_rd        = s.iir_rd;
    bus.thr_wr        = s.thr_wr;
    bus.iir_code      = s.iir_code;
    bus.cfg_fifo_en   = s.cfg_fifo_en;
    bus.cfg_rx_trig   = s.cfg_rx_trig;
    bus.cfg_thr_en    = s.cfg_thr_en;
    @(posedge clk);
    #1;
    model_step(s);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {bus.lsr_err, bus.int_rx_line_status, bus.int_rx_data_ready,
           bus.int_rx_timeout, bus.int_tx_fifo_empty};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic add(input stim_t s, input logic [7:0] exp, input string name);
    vec_t v;
    v.s = s; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    stim_t v = idle_stim();
    v.rst = 1'b1;                                   add(v, 8'b0000_0000, "reset");
    v = strobes_off(v);                             add(v, 8'b0000_0000, "idle_after_reset");
    v.rx_push = 1'b1; v.rx_err = 3'b010;            add(v, 8'b0100_1000, "fe_set");
    v = strobes_off(v);                             add(v, 8'b0100_1000, "fe_sticky");
    v.lsr_rd = 1'b1;                                add(v, 8'b0000_0000, "lsr_rd_clear");
    v = strobes_off(v); v.rx_push = 1'b1; v.rx_err = 3'b001; add(v, 8'b0010_1000, "pe_set");
    v = strobes_off(v); v.lsr_rd = 1'b1; v.rx_overrun = 1'b1; add(v, 8'b0001_1000, "rd_keeps_new_oe");
    v = strobes_off(v); v.lsr_rd = 1'b1;            add(v, 8'b0000_0000, "oe_clear");
    v = strobes_off(v); v.rx_err = 3'b111;          add(v, 8'b0000_0000, "err_needs_push");
    v = strobes_off(v); v.cfg_rx_trig = 2'd2; v.rx_level = 5'd7; add(v, 8'b0000_0000, "trig8_level7");
    v.rx_level = 5'd8;                              add(v, 8'b0000_0100, "trig8_level8");
    v.rx_level = 5'd7; v.rbr_rd = 1'b1;             add(v, 8'b0000_0000, "trig8_back7");
    v = strobes_off(v); v.cfg_rx_trig = 2'd3; v.rx_level = 5'd13; add(v, 8'b0000_0000, "trig14_level13");
    v.rx_level = 5'd14;                             add(v, 8'b0000_0100, "trig14_level14");
    v.cfg_fifo_en = 1'b0; v.rx_level = 5'd1;        add(v, 8'b0000_0100, "nofifo_level1");
    v.char_tick = 1'b1;
    for (int i = 0; i < 5; i++)                     add(v, 8'b0000_0100, "nofifo_no_timeout");
    v = strobes_off(v); v.cfg_fifo_en = 1'b1; v.rx_level = 5'd3; add(v, 8'b0000_0000, "to_start");
    v.char_tick = 1'b1;
    for (int i = 1; i <= 3; i++)                    add(v, 8'b0000_0000, "to_tick_pre");
    add(v, 8'b0000_0010, "to_4th_tick");
    v.char_tick = 1'b0;                             add(v, 8'b0000_0010, "to_holds");
    v.char_tick = 1'b1;                             add(v, 8'b0000_0010, "to_saturate");
    v = strobes_off(v); v.rbr_rd = 1'b1;            add(v, 8'b0000_0000, "to_rbr_clear");
    v = strobes_off(v); v.char_tick = 1'b1;
    for (int i = 1; i <= 4; i++)                    add(v, (i == 4) ? 8'b0000_0010 : 8'b0000_0000, "to_restart");
    v = strobes_off(v); v.rx_push = 1'b1;           add(v, 8'b0000_0000, "to_push_clear");
    v = strobes_off(v); v.char_tick = 1'b1;
    for (int i = 1; i <= 4; i++)                    add(v, (i == 4) ? 8'b0000_0010 : 8'b0000_0000, "to_recount");
    v.rx_level = 5'd0;                              add(v, 8'b0000_0000, "to_level0_clear");
    v = strobes_off(v); v.tx_fifo_empty = 1'b0;     add(v, 8'b0000_0000, "tx_busy");
    v.tx_fifo_empty = 1'b1;                         add(v, 8'b0000_0001, "thre_rise");
    v.iir_rd = 1'b1; v.iir_code = INT_RX_DATA_READY; add(v, 8'b0000_0001, "iir_other_keeps");
    v.iir_code = INT_THR_EMPTY;                     add(v, 8'b0000_0000, "iir_thr_clear");
    v = strobes_off(v); v.cfg_thr_en = 1'b1;        add(v, 8'b0000_0001, "etbei_rise");
    v.thr_wr = 1'b1;                                add(v, 8'b0000_0000, "thr_wr_clear");
    v = strobes_off(v); v.cfg_thr_en = 1'b0;        add(v, 8'b0000_0000, "etbei_low");
    v.cfg_thr_en = 1'b1; v.thr_wr = 1'b1;           add(v, 8'b0000_0000, "thr_wr_beats_set");
    v = strobes_off(v);                             add(v, 8'b0000_0000, "etbei_held_no_edge");
    v.tx_fifo_empty = 1'b0;                         add(v, 8'b0000_0000, "tx_busy2");
    v.tx_fifo_empty = 1'b1; v.iir_rd = 1'b1; v.iir_code = INT_THR_EMPTY; add(v, 8'b0000_0001, "set_beats_iir");
    v = strobes_off(v); v.cfg_thr_en = 1'b0; v.cfg_rx_trig = 2'd0; v.rx_level = 5'd3;
    v.rx_push = 1'b1; v.rx_err = 3'b100;            add(v, 8'b1000_1101, "pre_rst_flags");
    v = strobes_off(v); v.char_tick = 1'b1;
    for (int i = 0; i < 3; i++)                     add(v, 8'b1000_1101, "pre_rst_count");
    v.rst = 1'b1;                                   add(v, 8'b0000_0000, "rst_clears");
    v.rst = 1'b0;                                   add(v, 8'b0000_0100, "post_rst_no_thre");
    add(v, 8'b0000_0100, "post_rst_count2");
    add(v, 8'b0000_0100, "post_rst_count3");
    add(v, 8'b0000_0110, "post_rst_timeout");
  endtask

  initial begin
    stim_t     s;
    logic      cur_tx;
    logic      cur_en;
    logic      cur_thr_en;
    logic [1:0] cur_trig;
    int        cur_level;
    int_code_e codes[4] = '{INT_NONE, INT_THR_EMPTY, INT_RX_DATA_READY, INT_RX_LINE_STATUS};

    build_table();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    cur_tx = 1'b1; cur_en = 1'b1; cur_thr_en = 1'b0; cur_trig = 2'd1; cur_level = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)  cur_level = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 16));
      if ($urandom_range(0, 7) == 0)  cur_tx = ~cur_tx;
      if ($urandom_range(0, 49) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 9) == 0)  cur_thr_en = ~cur_thr_en;
      if ($urandom_range(0, 39) == 0) cur_trig = 2'($urandom);
      s = idle_stim();
      s.rst           = ($urandom_range(0, 99) == 0);
      s.rx_push       = ($urandom_range(0, 9) == 0);
      s.rx_err        = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      s.rx_overrun    = ($urandom_range(0, 31) == 0);
      s.rx_level      = LW'(cur_level);
      s.tx_fifo_empty = cur_tx;
      s.char_tick     = ($urandom_range(0, 2) == 0);
      s.lsr_rd        = ($urandom_range(0, 9) == 0);
      s.rbr_rd        = ($urandom_range(0, 11) == 0);
      s.iir_rd        = ($urandom_range(0, 5) == 0);
      s.iir_code      = codes[$urandom_range(0, 3)];
      s.thr_wr        = ($urandom_range(0, 11) == 0);
      s.cfg_fifo_en   = cur_en;
      s.cfg_rx_trig   = cur_trig;
      s.cfg_thr_en    = cur_thr_en;
      applyStimulus(s);
      checkOutput($sformatf("rand_%0d", i), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
